reg_file_pc: RTL

Parametrised successor to the core's 8x16 general register file, with two combinational read ports and one write port. Adds:
- a dedicated program-counter port (increment/load) on register PC_IDX;
- a per-register pending-write scoreboard, so the multi-cycle control FSM can detect hazards;
- a post-reset clear sequencer that zeroes every register.

Sits between decode/control and the ALU/write-back mux of the multi-cycle datapath.

---
 rtl/reg_file_pc_pkg.sv | 13 +
 rtl/reg_file_pc_if.sv | 37 +++
 rtl/rf_scoreboard.sv | 38 +++
 rtl/reg_file_pc.sv | 132 +++++++++++++
 4 files changed

// File: rtl/reg_file_pc_pkg.sv
// Shared types and default geometry for the reg_file_pc register file.
package reg_file_pc_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } rf_state_e;

    localparam int RF_DW     = 16;
    localparam int RF_NREG   = 8;
    localparam int RF_PC_IDX = 7;

endpackage

// File: rtl/reg_file_pc_if.sv
// Read/write/PC/scoreboard bundle between control, datapath and reg_file_pc.
interface reg_file_pc_if #(
    parameter int DW   = reg_file_pc_pkg::RF_DW,
    parameter int NREG = reg_file_pc_pkg::RF_NREG
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0] addrA;
    logic [AW-1:0] addrB;
    logic [AW-1:0] addrC;
    logic [AW-1:0] busy_addr;
    logic [DW-1:0] output_A;
    logic [DW-1:0] output_B;
    logic [DW-1:0] data_write;
    logic [DW-1:0] pc_out;
    logic [DW-1:0] pc_data;
    logic          regw;
    logic          pc_inc;
    logic          pc_load;
    logic          busy_set;
    logic          busy_A;
    logic          busy_B;
    logic          ready;

    modport slave (
        input  addrA, addrB, addrC, data_write, regw,
        input  pc_inc, pc_load, pc_data, busy_set, busy_addr,
        output output_A, output_B, pc_out, busy_A, busy_B, ready
    );

    modport master (
        output addrA, addrB, addrC, data_write, regw,
        output pc_inc, pc_load, pc_data, busy_set, busy_addr,
        input  output_A, output_B, pc_out, busy_A, busy_B, ready
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits: set by issue, cleared by write-back, set wins.
module rf_scoreboard #(
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic          busy_a,
    output logic          busy_b
);

    localparam logic [AW:0] NREG_W = (AW + 1)'(NREG);

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;

    // Enables arrive pre-qualified; the later assignment gives set priority.
    always_comb begin
        sb_d = sb_q;
        if (clr_en) sb_d[clr_addr] = 1'b0;
        if (set_en) sb_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) sb_q <= '0;
        else       sb_q <= sb_d;
    end

    assign busy_a = ({1'b0, rd_addr_a} < NREG_W) ? sb_q[rd_addr_a] : 1'b0;
    assign busy_b = ({1'b0, rd_addr_b} < NREG_W) ? sb_q[rd_addr_b] : 1'b0;

endmodule

// File: rtl/reg_file_pc.sv
// Register file with PC port, pending-write scoreboard and post-reset clear.
// Define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_pc
    import reg_file_pc_pkg::*;
#(
    parameter int DW      = RF_DW,
    parameter int NREG    = RF_NREG,
    parameter int PC_IDX  = RF_PC_IDX,
    parameter int PC_STEP = 1
) (
    input logic         clk,
    input logic         reset,
    reg_file_pc_if.slave bus
);

    localparam int            AW     = $clog2(NREG);
    localparam logic [AW:0]   NREG_W = (AW + 1)'(NREG);
    localparam logic [AW-1:0] PC_A   = AW'(PC_IDX);
    localparam logic [AW-1:0] LAST_A = AW'(NREG - 1);
    localparam logic [DW-1:0] STEP_W = DW'(PC_STEP);

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NREG_W;
    endfunction

    rf_state_e     state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic          ready_q, ready_d;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];

    logic          idle;
    logic          wr_en;
    logic          set_en;
    logic [DW-1:0] pc_cur;
    logic [DW-1:0] pc_next;
    logic          sb_a;
    logic          sb_b;

    // NOTE: every output of a combinational block is assigned on every path
    // (defaults first or a full if/else chain) so no latch is inferred.
    always_comb begin
        idle   = (state_q == IDLE);
        wr_en  = idle && bus.regw && in_range(bus.addrC);
        set_en = idle && bus.busy_set && in_range(bus.busy_addr)
                 && (bus.busy_addr != PC_A);
        pc_cur = regs_q[PC_IDX];
        if (bus.pc_load)                      pc_next = bus.pc_data;
        else if (wr_en && bus.addrC == PC_A)  pc_next = bus.data_write;
        else if (bus.pc_inc)                  pc_next = pc_cur + STEP_W;
        else                                  pc_next = pc_cur;
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ready_d   = ready_q;
        regs_d    = regs_q;
        case (state_q)
            CLEAR: begin
                regs_d[clr_ptr_q] = '0;
                clr_ptr_d         = clr_ptr_q + AW'(1);
                if (clr_ptr_q == LAST_A) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                if (wr_en) regs_d[bus.addrC] = bus.data_write;
                regs_d[PC_IDX] = pc_next;
            end
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready_q   <= ready_d;
        end
    end

    // NOTE: the storage array is not reset; only the PC entry is, and the
    // clear sequencer zeroes the rest one entry per cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) regs_q[PC_IDX] <= '0;
        else       regs_q         <= regs_d;
    end

    rf_scoreboard #(.NREG(NREG)) u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_en    (set_en),
        .set_addr  (bus.busy_addr),
        .clr_en    (wr_en),
        .clr_addr  (bus.addrC),
        .rd_addr_a (bus.addrA),
        .rd_addr_b (bus.addrB),
        .busy_a    (sb_a),
        .busy_b    (sb_b)
    );

    always_comb begin
        bus.output_A = in_range(bus.addrA) ? regs_q[bus.addrA] : '0;
        bus.output_B = in_range(bus.addrB) ? regs_q[bus.addrB] : '0;
        bus.busy_A   = sb_a;
        bus.busy_B   = sb_b;
`ifdef RF_BYPASS_EN
        // A forwarded operand is already produced, so it is only busy if a
        // newer producer is issued against it in this same cycle.
        if (wr_en && bus.addrA == bus.addrC) begin
            bus.output_A = (bus.addrA == PC_A) ? pc_next : bus.data_write;
            bus.busy_A   = set_en && (bus.busy_addr == bus.addrA);
        end
        if (wr_en && bus.addrB == bus.addrC) begin
            bus.output_B = (bus.addrB == PC_A) ? pc_next : bus.data_write;
            bus.busy_B   = set_en && (bus.busy_addr == bus.addrB);
        end
`endif
    end

    assign bus.pc_out = regs_q[PC_IDX];
    assign bus.ready  = ready_q;

endmodule
